// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Holds the hazard FSM state encoding and the default register-index width.

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      MD_WAIT = 2'd2
   } pipe_ctrl_state_t;

   localparam int REG_ADDR_W_DEF = 5;

   // Width of the remaining-flush counter; covers FLUSH_CYCLES up to 7.
   localparam int FLUSH_LEFT_W = 3;

endpackage

// File: rtl/pipe_hazard_perf.sv
// rtl/pipe_hazard_perf.sv - saturating stall/flush cycle counters for the hazard controller
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_clr             synchronous clear, wins over an increment
//   i_stall           count one stall cycle
//   i_flush           count one IF/ID flush cycle
//   o_stall_cycles    saturating stall-cycle count
//   o_flush_cycles    saturating flush-cycle count

module pipe_hazard_perf #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_stall,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_cycles
);

   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_clr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         // Hold at all-ones instead of wrapping.
         if (i_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (i_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign o_stall_cycles = r_stall_cnt;
   assign o_flush_cycles = r_flush_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
//
// Resolves load-use hazards, taken branches/returns resolved in EX, and
// multi-cycle MUL/DIV operations. All controls are Mealy outputs of a
// three-state FSM (RUN, FLUSH, MD_WAIT) and act on the same edge the
// pipeline registers sample.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters (perf_clr, stall_cycles, flush_cycles, parameter CNT_W).
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   id_rs, id_rt                    source registers of the ID instruction
//   id_uses_rs, id_uses_rt          ID instruction actually reads rs/rt
//   ex_mem_read, ex_rd              EX instruction is a load / its destination
//   ex_branch_taken, ex_ret         redirect resolved in EX
//   ex_md_busy, ex_md_done          multi-cycle op status in EX
//   pc_we, if_id_we, id_ex_we       register load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                    load a bubble into the register
//   ctrl_state                      current FSM state (debug)
//   perf_clr, stall_cycles,
//   flush_cycles                    performance counters (macro only)

module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W        = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  ex_ret,
   input  logic                  ex_md_busy,
   input  logic                  ex_md_done,
   output logic                  pc_we,
   output logic                  if_id_we,
   output logic                  id_ex_we,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic                  perf_clr,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_cycles
`endif
);

   // Number of extra FLUSH-state cycles after the redirect cycle itself.
   localparam logic [FLUSH_LEFT_W-1:0] FLUSH_LOAD = FLUSH_LEFT_W'(FLUSH_CYCLES - 1);

   pipe_ctrl_state_t          r_state;
   pipe_ctrl_state_t          w_state_next;
   logic [FLUSH_LEFT_W-1:0]   r_flush_left;
   logic [FLUSH_LEFT_W-1:0]   w_flush_left_next;

   logic w_redirect;
   logic w_md_stall;
   logic w_rs_hit;
   logic w_rt_hit;
   logic w_load_use;

   assign w_redirect = ex_branch_taken | ex_ret;
   // busy together with done means the op finishes now: no stall needed.
   assign w_md_stall = ex_md_busy & ~ex_md_done;

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign w_rs_hit   = id_uses_rs & (id_rs == ex_rd);
   assign w_rt_hit   = id_uses_rt & (id_rt == ex_rd);
   assign w_load_use = ex_mem_read & (ex_rd != '0) & (w_rs_hit | w_rt_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RUN;
         r_flush_left <= '0;
      end else begin
         r_state      <= w_state_next;
         r_flush_left <= w_flush_left_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_flush_left_next = r_flush_left;
      pc_we             = 1'b1;
      if_id_we          = 1'b1;
      id_ex_we          = 1'b1;
      if_id_flush       = 1'b0;
      id_ex_flush       = 1'b0;
      ex_mem_flush      = 1'b0;

      unique case (r_state)
         RUN: begin
            if (w_redirect) begin
               // Redirect squashes the ID instruction, so it outranks any stall.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  w_state_next      = FLUSH;
                  w_flush_left_next = FLUSH_LOAD;
               end
            end else if (w_md_stall) begin
               pc_we        = 1'b0;
               if_id_we     = 1'b0;
               id_ex_we     = 1'b0;
               ex_mem_flush = 1'b1;
               w_state_next = MD_WAIT;
            end else if (w_load_use) begin
               // One bubble into EX; the condition clears next cycle by itself.
               pc_we       = 1'b0;
               if_id_we    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end

         FLUSH: begin
            // EX holds a bubble here, so redirect inputs cannot be live.
            if_id_flush = 1'b1;
            if (r_flush_left <= FLUSH_LEFT_W'(1)) begin
               w_state_next      = RUN;
               w_flush_left_next = '0;
            end else begin
               w_flush_left_next = r_flush_left - FLUSH_LEFT_W'(1);
            end
         end

         MD_WAIT: begin
            if (ex_md_done) begin
               w_state_next = RUN;
            end else begin
               pc_we        = 1'b0;
               if_id_we     = 1'b0;
               id_ex_we     = 1'b0;
               ex_mem_flush = 1'b1;
            end
         end

         default: begin
            w_state_next      = RUN;
            w_flush_left_next = '0;
         end
      endcase

      // Hold the whole pipeline frozen and bubbled while in reset.
      if (rst) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end
   end

   assign ctrl_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
   pipe_hazard_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (perf_clr),
      .i_stall        (~pc_we),
      .i_flush        (if_id_flush),
      .o_stall_cycles (stall_cycles),
      .o_flush_cycles (flush_cycles)
   );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

   localparam int RW = 5;
   localparam int FC = 3;
`ifdef HAZARD_PERF_CNT_EN
   localparam int CW = 4;
`endif

   logic          clk;
   logic          rst;
   logic [RW-1:0] id_rs, id_rt, ex_rd;
   logic          id_uses_rs, id_uses_rt, ex_mem_read;
   logic          ex_branch_taken, ex_ret, ex_md_busy, ex_md_done;
   logic          pc_we, if_id_we, id_ex_we;
   logic          if_id_flush, id_ex_flush, ex_mem_flush;
   logic [1:0]    ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
   logic          perf_clr;
   logic [CW-1:0] stall_cycles, flush_cycles;
`endif

   int n_asserts;
   int n_fail;

   // Expected-behaviour model state: remaining FLUSH cycles and MD wait flag.
   int m_flush_rem;
   bit m_md_wait;
`ifdef HAZARD_PERF_CNT_EN
   int m_stall_cnt;
   int m_flush_cnt;
`endif

   pipe_hazard_ctrl #(
      .REG_ADDR_W   (RW),
      .FLUSH_CYCLES (FC)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .CNT_W        (CW)
`endif
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .ex_ret          (ex_ret),
      .ex_md_busy      (ex_md_busy),
      .ex_md_done      (ex_md_done),
      .pc_we           (pc_we),
      .if_id_we        (if_id_we),
      .id_ex_we        (id_ex_we),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_flush    (ex_mem_flush),
      .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_clr        (perf_clr),
      .stall_cycles    (stall_cycles),
      .flush_cycles    (flush_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state}
   wire [7:0] obs_vec = {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush,
                         ex_mem_flush, ctrl_state};

   localparam logic [7:0] V_RESET   = 8'b000_111_00;
   localparam logic [7:0] V_RUN     = 8'b111_000_00;
   localparam logic [7:0] V_LOADUSE = 8'b001_010_00;
   localparam logic [7:0] V_REDIR   = 8'b111_110_00;
   localparam logic [7:0] V_FLUSH   = 8'b111_100_01;
   localparam logic [7:0] V_MD_RUN  = 8'b000_001_00;
   localparam logic [7:0] V_MD_WAIT = 8'b000_001_10;
   localparam logic [7:0] V_MD_DONE = 8'b111_000_10;

   function automatic logic [7:0] model_out();
      bit redir, lu, mds;
      redir = ex_branch_taken || ex_ret;
      mds   = ex_md_busy && !ex_md_done;
      lu    = ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      if (rst)             return V_RESET;
      if (m_flush_rem > 0) return V_FLUSH;
      if (m_md_wait)       return ex_md_done ? V_MD_DONE : V_MD_WAIT;
      if (redir)           return V_REDIR;
      if (mds)             return V_MD_RUN;
      if (lu)              return V_LOADUSE;
      return V_RUN;
   endfunction

   task automatic model_step();
      logic [7:0] e;
      e = model_out();
      if (rst) begin
         m_flush_rem = 0;
         m_md_wait   = 0;
`ifdef HAZARD_PERF_CNT_EN
         m_stall_cnt = 0;
         m_flush_cnt = 0;
`endif
         return;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (perf_clr) begin
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (!e[7] && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
         if (e[4]  && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
      end
`endif
      if (m_flush_rem > 0)                   m_flush_rem--;
      else if (m_md_wait)                    m_md_wait = !ex_md_done;
      else if (ex_branch_taken || ex_ret)    m_flush_rem = FC - 1;
      else if (ex_md_busy && !ex_md_done)    m_md_wait = 1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check at the falling edge, advance the model, then move past the next rising edge.
   task automatic cyc(input string tag);
      @(negedge clk);
      chk(tag, 16'(obs_vec), 16'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, "_stall_cnt"}, 16'(stall_cycles), 16'(m_stall_cnt));
      chk({tag, "_flush_cnt"}, 16'(flush_cycles), 16'(m_flush_cnt));
`endif
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Same as cyc, plus a fixed expectation for this directed step.
   task automatic cyc_k(input string tag, input logic [7:0] k);
      @(negedge clk);
      chk({tag, "_k"}, 16'(obs_vec), 16'(k));
      chk(tag, 16'(obs_vec), 16'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, "_stall_cnt"}, 16'(stall_cycles), 16'(m_stall_cnt));
      chk({tag, "_flush_cnt"}, 16'(flush_cycles), 16'(m_flush_cnt));
`endif
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
      ex_branch_taken = 0; ex_ret = 0; ex_md_busy = 0; ex_md_done = 0;
`ifdef HAZARD_PERF_CNT_EN
      perf_clr = 0;
`endif
   endtask

   initial begin
      n_asserts   = 0;
      n_fail      = 0;
      m_flush_rem = 0;
      m_md_wait   = 0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall_cnt = 0;
      m_flush_cnt = 0;
`endif
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      cyc_k("reset", V_RESET);
      rst = 1'b0;
      cyc_k("post_reset", V_RUN);

      // Load-use on rs, then the bubble removes the dependency.
      ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
      cyc_k("loaduse", V_LOADUSE);
      ex_mem_read = 0;
      cyc_k("loaduse_after", V_RUN);
      // Same on rt.
      ex_mem_read = 1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1; id_uses_rs = 0;
      cyc_k("loaduse_rt", V_LOADUSE);
      // Register 0 never stalls.
      ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1; id_uses_rt = 1;
      cyc_k("loaduse_r0", V_RUN);
      idle_inputs();

      // Taken branch: 3 flush cycles, states 0,1,1 then 0; redirect ignored in FLUSH.
      ex_branch_taken = 1;
      cyc_k("br0", V_REDIR);
      ex_branch_taken = 0;
      cyc_k("br1", V_FLUSH);
      ex_ret = 1;
      cyc_k("br2", V_FLUSH);
      ex_ret = 0;
      cyc_k("br3", V_RUN);

      // MD op: busy 4 cycles, done in the 4th.
      ex_md_busy = 1;
      cyc_k("md0", V_MD_RUN);
      cyc_k("md1", V_MD_WAIT);
      cyc_k("md2", V_MD_WAIT);
      ex_md_done = 1;
      cyc_k("md3", V_MD_DONE);
      idle_inputs();
      cyc_k("md4", V_RUN);

      // Redirect plus load-use: redirect wins.
      ex_ret = 1; ex_mem_read = 1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1;
      cyc_k("ret_lu0", V_REDIR);
      idle_inputs();
      cyc_k("ret_lu1", V_FLUSH);
      cyc_k("ret_lu2", V_FLUSH);
      cyc_k("ret_lu3", V_RUN);

      // busy with done in RUN: no stall.
      ex_md_busy = 1; ex_md_done = 1;
      cyc_k("md_fast", V_RUN);
      idle_inputs();

      // Reset while in MD_WAIT.
      ex_md_busy = 1;
      cyc_k("mdrst0", V_MD_RUN);
      cyc_k("mdrst1", V_MD_WAIT);
      rst = 1;
      cyc_k("mdrst2", V_RESET);
      rst = 0;
      idle_inputs();
      cyc_k("mdrst3", V_RUN);

`ifdef HAZARD_PERF_CNT_EN
      // 20 stall cycles saturate a 4-bit counter at 15; perf_clr empties it.
      perf_clr = 1;
      cyc("perf_clr0");
      perf_clr = 0;
      ex_md_busy = 1;
      for (int i = 0; i < 20; i++) cyc("perf_stall");
      ex_md_done = 1;
      @(negedge clk);
      chk("perf_sat", 16'(stall_cycles), 16'd15);
      @(posedge clk);
      #1;
      m_stall_cnt = m_stall_cnt;
      model_step();
      idle_inputs();
      perf_clr = 1;
      cyc("perf_clr1");
      perf_clr = 0;
      @(negedge clk);
      chk("perf_zero", 16'(stall_cycles), 16'd0);
      @(posedge clk);
      #1;
      model_step();
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         id_rs           = RW'($urandom_range(0, 3));
         id_rt           = RW'($urandom_range(0, 3));
         ex_rd           = RW'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         ex_ret          = ($urandom_range(0, 11) == 0);
         ex_md_busy      = 1'($urandom_range(0, 1));
         ex_md_done      = ($urandom_range(0, 3) == 0);
         rst             = ($urandom_range(0, 39) == 0);
`ifdef HAZARD_PERF_CNT_EN
         perf_clr        = ($urandom_range(0, 15) == 0);
`endif
         cyc("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
